// File: rtl/intr_ctrl.sv
// intr_ctrl: 8085-style interrupt controller (TRAP, RST7.5/6.5/5.5, INTR).
// Latches and masks sources, runs SIM/RIM and EI delay, and arbitrates at
// instruction boundaries.
//
// Ports:
//   clk_, rst_           clock, async active-high reset
//   trap, rst75, rst65,  interrupt pins (synchronous to clk_)
//   rst55, intr
//   sid                  serial input pin
//   inst_ei, inst_di,    decoder pulses
//   inst_sim, sim_dat    SIM pulse and accumulator value
//   sample               instruction boundary pulse
//   int_ack              acknowledge / restart cycle started
//   int_req, int_src,    accepted request, its source code,
//   int_vec, int_ext     restart vector and external-opcode flag
//   wake                 any eligible request (halt exit)
//   inte                 interrupt-enable flag
//   sod                  serial output pin
//   rim_dat              RIM value
module intr_ctrl (
   input  logic        clk_,
   input  logic        rst_,
   input  logic        trap,
   input  logic        rst75,
   input  logic        rst65,
   input  logic        rst55,
   input  logic        intr,
   input  logic        sid,
   input  logic        inst_ei,
   input  logic        inst_di,
   input  logic        inst_sim,
   input  logic [7:0]  sim_dat,
   input  logic        sample,
   input  logic        int_ack,
   output logic        int_req,
   output logic [2:0]  int_src,
   output logic [15:0] int_vec,
   output logic        int_ext,
   output logic        wake,
   output logic        inte,
   output logic        sod,
   output logic [7:0]  rim_dat
);

   localparam logic IDLE = 1'b0;
   localparam logic PEND = 1'b1;

   localparam logic [2:0] SRC_NONE = 3'd0;
   localparam logic [2:0] SRC_TRAP = 3'd1;
   localparam logic [2:0] SRC_R75  = 3'd2;
   localparam logic [2:0] SRC_R65  = 3'd3;
   localparam logic [2:0] SRC_R55  = 3'd4;
   localparam logic [2:0] SRC_INTR = 3'd5;

   localparam logic [15:0] VEC_TRAP = 16'h0024;
   localparam logic [15:0] VEC_R75  = 16'h003C;
   localparam logic [15:0] VEC_R65  = 16'h0034;
   localparam logic [15:0] VEC_R55  = 16'h002C;

   logic       state;
   logic       trap_q;
   logic       r75_q;
   logic       trap_lat;
   logic       r75_lat;
   logic [2:0] m;
   logic       ie;
   logic       ei_dly;
   logic       sod_r;

   logic       trap_edge;
   logic       r75_edge;
   logic       req_trap;
   logic       req_r75;
   logic       req_r65;
   logic       req_r55;
   logic       req_intr;
   logic       ack_ok;
   logic       smp_ok;
   logic       sim_clr75;
   logic [2:0] sel_src;
   logic [15:0] sel_vec;
   logic       sel_ext;
   logic       unused_sim5;

   assign unused_sim5 = sim_dat[5];

   // ------------------------------------------------------------
   // Source qualification
   // ------------------------------------------------------------
   assign trap_edge = trap & ~trap_q;
   assign r75_edge  = rst75 & ~r75_q;

   // TRAP needs both the latched edge and the level still present
   assign req_trap = trap_lat & trap;
   assign req_r75  = r75_lat & ~m[2] & ie;
   assign req_r65  = rst65 & ~m[1] & ie;
   assign req_r55  = rst55 & ~m[0] & ie;
   assign req_intr = intr & ie;

   assign wake = req_trap | req_r75 | req_r65 | req_r55 | req_intr;

   assign ack_ok    = (state == PEND) & int_ack;
   assign smp_ok    = (state == IDLE) & sample;
   assign sim_clr75 = inst_sim & sim_dat[4];

   // ------------------------------------------------------------
   // Fixed-priority select
   // ------------------------------------------------------------
   always_comb begin
      sel_src = SRC_NONE;
      sel_vec = 16'h0000;
      sel_ext = 1'b0;
      priority case (1'b1)
         req_trap: begin
            sel_src = SRC_TRAP;
            sel_vec = VEC_TRAP;
         end
         req_r75: begin
            sel_src = SRC_R75;
            sel_vec = VEC_R75;
         end
         req_r65: begin
            sel_src = SRC_R65;
            sel_vec = VEC_R65;
         end
         req_r55: begin
            sel_src = SRC_R55;
            sel_vec = VEC_R55;
         end
         req_intr: begin
            sel_src = SRC_INTR;
            sel_ext = 1'b1;
         end
         default: begin
            sel_src = SRC_NONE;
         end
      endcase
   end

   // ------------------------------------------------------------
   // Pin history and edge latches
   // ------------------------------------------------------------
   always_ff @(posedge clk_ or posedge rst_) begin
      if (rst_) begin
         trap_q <= 1'b0;
         r75_q  <= 1'b0;
      end else begin
         trap_q <= trap;
         r75_q  <= rst75;
      end
   end

   // A new edge beats a clear arriving in the same cycle
   always_ff @(posedge clk_ or posedge rst_) begin
      if (rst_) begin
         trap_lat <= 1'b0;
      end else if (trap_edge) begin
         trap_lat <= 1'b1;
      end else if (ack_ok && int_src == SRC_TRAP) begin
         trap_lat <= 1'b0;
      end
   end

   always_ff @(posedge clk_ or posedge rst_) begin
      if (rst_) begin
         r75_lat <= 1'b0;
      end else if (r75_edge) begin
         r75_lat <= 1'b1;
      end else if (sim_clr75 ||
                   (ack_ok && int_src == SRC_R75)) begin
         r75_lat <= 1'b0;
      end
   end

   // ------------------------------------------------------------
   // SIM: mask and serial output
   // ------------------------------------------------------------
   always_ff @(posedge clk_ or posedge rst_) begin
      if (rst_) begin
         m     <= 3'b111;
         sod_r <= 1'b0;
      end else if (inst_sim) begin
         if (sim_dat[3]) m <= sim_dat[2:0];
         if (sim_dat[6]) sod_r <= sim_dat[7];
      end
   end

   // ------------------------------------------------------------
   // Interrupt enable with one-instruction EI delay.
   // Later statements override earlier ones: DI wins over all.
   // ------------------------------------------------------------
   always_ff @(posedge clk_ or posedge rst_) begin
      if (rst_) begin
         ie     <= 1'b0;
         ei_dly <= 1'b0;
      end else begin
         if (smp_ok) begin
            ie     <= ei_dly;
            ei_dly <= 1'b0;
         end
         if (inst_ei) begin
            ei_dly <= 1'b1;
         end
         if (ack_ok) begin
            ie     <= 1'b0;
            ei_dly <= 1'b0;
         end
         if (inst_di) begin
            ie     <= 1'b0;
            ei_dly <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------
   // Request state machine
   // ------------------------------------------------------------
   always_ff @(posedge clk_ or posedge rst_) begin
      if (rst_) begin
         state   <= IDLE;
         int_src <= SRC_NONE;
         int_vec <= 16'h0000;
         int_ext <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sample && wake) begin
                  state   <= PEND;
                  int_src <= sel_src;
                  int_vec <= sel_vec;
                  int_ext <= sel_ext;
               end
            end
            PEND: begin
               // sample is ignored here; ack returns to IDLE
               if (int_ack) begin
                  state   <= IDLE;
                  int_src <= SRC_NONE;
                  int_vec <= 16'h0000;
                  int_ext <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------
   assign int_req = (state == PEND);
   assign inte    = ie;
   assign sod     = sod_r;

   // Pin fields are forced low during reset so RIM reads its reset pattern
   assign rim_dat = {sid, r75_lat, rst65 & ~rst_, rst55 & ~rst_,
                     ie, m};

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed self-checking bench for intr_ctrl.
// One task per scenario, each with inline comparisons.
module tb_intr_ctrl;

   logic        clk_ = 1'b0;
   logic        rst_;
   logic        trap, rst75, rst65, rst55, intr, sid;
   logic        inst_ei, inst_di, inst_sim;
   logic [7:0]  sim_dat;
   logic        sample, int_ack;
   logic        int_req;
   logic [2:0]  int_src;
   logic [15:0] int_vec;
   logic        int_ext, wake, inte, sod;
   logic [7:0]  rim_dat;

   int errors = 0;
   int checks = 0;

   intr_ctrl dut (
      .clk_     (clk_),
      .rst_     (rst_),
      .trap     (trap),
      .rst75    (rst75),
      .rst65    (rst65),
      .rst55    (rst55),
      .intr     (intr),
      .sid      (sid),
      .inst_ei  (inst_ei),
      .inst_di  (inst_di),
      .inst_sim (inst_sim),
      .sim_dat  (sim_dat),
      .sample   (sample),
      .int_ack  (int_ack),
      .int_req  (int_req),
      .int_src  (int_src),
      .int_vec  (int_vec),
      .int_ext  (int_ext),
      .wake     (wake),
      .inte     (inte),
      .sod      (sod),
      .rim_dat  (rim_dat)
   );

   always #5 clk_ = ~clk_;

   task automatic tick();
      @(posedge clk_);
      #1;
   endtask

   task automatic do_sim(input logic [7:0] d);
      inst_sim = 1'b1;
      sim_dat  = d;
      tick();
      inst_sim = 1'b0;
      sim_dat  = 8'h00;
   endtask

   task automatic do_sample();
      sample = 1'b1;
      tick();
      sample = 1'b0;
   endtask

   task automatic do_ack();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic do_ei();
      inst_ei = 1'b1;
      tick();
      inst_ei = 1'b0;
   endtask

   task automatic test_reset();
      rst_ = 1'b1;
      tick();
      tick();
      rst_ = 1'b0;
      tick();
      checks++;
      if (int_req !== 1'b0 || int_src !== 3'd0 ||
          int_vec !== 16'h0000 || int_ext !== 1'b0) begin
         errors++;
         $display("FAIL reset_req got req=%b src=%0d vec=%h ext=%b want 0",
                  int_req, int_src, int_vec, int_ext);
      end
      checks++;
      if (wake !== 1'b0 || inte !== 1'b0 || sod !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got wake=%b inte=%b sod=%b want 0",
                  wake, inte, sod);
      end
      checks++;
      if (rim_dat !== 8'h87) begin
         errors++;
         $display("FAIL reset_rim got %h want 87", rim_dat);
      end
   endtask

   task automatic test_ei_delay();
      do_sim(8'h08);
      rst55 = 1'b1;
      do_ei();
      do_sample();
      checks++;
      if (int_req !== 1'b0 || inte !== 1'b1) begin
         errors++;
         $display("FAIL ei_delay got req=%b inte=%b want req=0 inte=1",
                  int_req, inte);
      end
      do_sample();
      checks++;
      if (int_req !== 1'b1 || int_src !== 3'd4 ||
          int_vec !== 16'h002C) begin
         errors++;
         $display("FAIL r55_take got req=%b src=%0d vec=%h want 1 4 002c",
                  int_req, int_src, int_vec);
      end
      do_ack();
      checks++;
      if (inte !== 1'b0 || int_req !== 1'b0 || int_src !== 3'd0) begin
         errors++;
         $display("FAIL r55_ack got inte=%b req=%b src=%0d want 0 0 0",
                  inte, int_req, int_src);
      end
      rst55 = 1'b0;
      tick();
   endtask

   task automatic test_priority();
      do_ei();
      do_sample();
      rst65 = 1'b1;
      rst55 = 1'b1;
      intr  = 1'b1;
      rst75 = 1'b1;
      tick();
      checks++;
      if (wake !== 1'b1) begin
         errors++;
         $display("FAIL prio_wake got %b want 1", wake);
      end
      do_sample();
      checks++;
      if (int_src !== 3'd2 || int_vec !== 16'h003C || int_ext !== 1'b0) begin
         errors++;
         $display("FAIL prio_r75 got src=%0d vec=%h ext=%b want 2 003c 0",
                  int_src, int_vec, int_ext);
      end
      do_ack();
      checks++;
      if (rim_dat[6] !== 1'b0 || inte !== 1'b0) begin
         errors++;
         $display("FAIL prio_ack got p75=%b inte=%b want 0 0",
                  rim_dat[6], inte);
      end
      rst65 = 1'b0;
      rst55 = 1'b0;
      intr  = 1'b0;
      rst75 = 1'b0;
      tick();
   endtask

   task automatic test_trap();
      trap = 1'b1;
      tick();
      do_sample();
      checks++;
      if (int_req !== 1'b1 || int_src !== 3'd1 ||
          int_vec !== 16'h0024) begin
         errors++;
         $display("FAIL trap_take got req=%b src=%0d vec=%h want 1 1 0024",
                  int_req, int_src, int_vec);
      end
      do_ack();
      trap = 1'b0;
      tick();
      trap = 1'b1;
      tick();
      trap = 1'b0;
      tick();
      checks++;
      if (wake !== 1'b0) begin
         errors++;
         $display("FAIL trap_pulse_wake got %b want 0", wake);
      end
      do_sample();
      checks++;
      if (int_req !== 1'b0) begin
         errors++;
         $display("FAIL trap_pulse got req=%b want 0", int_req);
      end
   endtask

   task automatic test_sim();
      do_sim(8'h0E);
      checks++;
      if (rim_dat[2:0] !== 3'b110) begin
         errors++;
         $display("FAIL sim_mask got %b want 110", rim_dat[2:0]);
      end
      rst75 = 1'b1;
      tick();
      checks++;
      if (rim_dat[6] !== 1'b1 || wake !== 1'b0) begin
         errors++;
         $display("FAIL r75_masked_latch got p75=%b wake=%b want 1 0",
                  rim_dat[6], wake);
      end
      do_sim(8'h10);
      checks++;
      if (rim_dat[6] !== 1'b0 || sod !== 1'b0 ||
          rim_dat[2:0] !== 3'b110) begin
         errors++;
         $display("FAIL sim_clr75 got p75=%b sod=%b m=%b want 0 0 110",
                  rim_dat[6], sod, rim_dat[2:0]);
      end
      do_sim(8'hC0);
      checks++;
      if (sod !== 1'b1) begin
         errors++;
         $display("FAIL sim_sod got %b want 1", sod);
      end
      rst75 = 1'b0;
      tick();
   endtask

   task automatic test_intr_reset();
      do_ei();
      do_sample();
      intr = 1'b1;
      do_sample();
      checks++;
      if (int_src !== 3'd5 || int_ext !== 1'b1 || int_vec !== 16'h0000) begin
         errors++;
         $display("FAIL intr_take got src=%0d ext=%b vec=%h want 5 1 0000",
                  int_src, int_ext, int_vec);
      end
      rst_ = 1'b1;
      #1;
      checks++;
      if (int_req !== 1'b0 || rim_dat[2:0] !== 3'b111 ||
          int_ext !== 1'b0 || sod !== 1'b0) begin
         errors++;
         $display("FAIL pend_reset got req=%b m=%b ext=%b sod=%b want 0 111 0 0",
                  int_req, rim_dat[2:0], int_ext, sod);
      end
      #2;
      rst_ = 1'b0;
      intr = 1'b0;
      tick();
   endtask

   task automatic test_pend_hold();
      do_sim(8'h08);
      do_ei();
      do_sample();
      rst55 = 1'b1;
      do_sample();
      rst75 = 1'b1;
      tick();
      checks++;
      if (int_req !== 1'b1 || int_src !== 3'd4) begin
         errors++;
         $display("FAIL pend_hold got req=%b src=%0d want 1 4",
                  int_req, int_src);
      end
      do_sample();
      checks++;
      if (int_src !== 3'd4 || int_vec !== 16'h002C) begin
         errors++;
         $display("FAIL pend_sample got src=%0d vec=%h want 4 002c",
                  int_src, int_vec);
      end
      rst75 = 1'b0;
      tick();
      int_ack  = 1'b1;
      inst_sim = 1'b1;
      sim_dat  = 8'h10;
      rst75    = 1'b1;
      tick();
      int_ack  = 1'b0;
      inst_sim = 1'b0;
      sim_dat  = 8'h00;
      checks++;
      if (rim_dat[6] !== 1'b1 || int_req !== 1'b0) begin
         errors++;
         $display("FAIL set_wins got p75=%b req=%b want 1 0",
                  rim_dat[6], int_req);
      end
      rst75 = 1'b0;
      rst55 = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      inst_ei = 1'b1;
      inst_di = 1'b1;
      tick();
      inst_ei = 1'b0;
      inst_di = 1'b0;
      do_sample();
      checks++;
      if (inte !== 1'b0) begin
         errors++;
         $display("FAIL ei_di got inte=%b want 0", inte);
      end
      trap = 1'b1;
      tick();
      do_sample();
      checks++;
      if (int_src !== 3'd1) begin
         errors++;
         $display("FAIL b2b_trap got src=%0d want 1", int_src);
      end
      sample  = 1'b1;
      int_ack = 1'b1;
      tick();
      sample  = 1'b0;
      int_ack = 1'b0;
      checks++;
      if (int_req !== 1'b0 || int_src !== 3'd0) begin
         errors++;
         $display("FAIL ack_sample got req=%b src=%0d want 0 0",
                  int_req, int_src);
      end
      do_sample();
      checks++;
      if (int_req !== 1'b0) begin
         errors++;
         $display("FAIL trap_cleared got req=%b want 0", int_req);
      end
      trap = 1'b0;
      tick();
   endtask

   initial begin
      rst_     = 1'b0;
      trap     = 1'b0;
      rst75    = 1'b0;
      rst65    = 1'b0;
      rst55    = 1'b0;
      intr     = 1'b0;
      sid      = 1'b1;
      inst_ei  = 1'b0;
      inst_di  = 1'b0;
      inst_sim = 1'b0;
      sim_dat  = 8'h00;
      sample   = 1'b0;
      int_ack  = 1'b0;
      #2;
      test_reset();
      test_ei_delay();
      test_priority();
      test_trap();
      test_sim();
      test_intr_reset();
      test_pend_hold();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
